regfile_sequencer: RTL and testbench

- Four-phase (Q1–Q4) instruction-cycle controller for the PIC16C57 core.
- Latches each 12-bit instruction, decodes it, and drives the register file: address, write, PC increment and status update.
- Also drives the W-register write enable, GOTO target loading and skip handling.
- Sits between program memory, the register file and the external ALU. Orders register-file commands so that write, PCInc and StatusEn never coincide; the register file prioritises write over PCInc over StatusEn.

---
 rtl/regfile_seq_pkg.sv | 55 +++++
 rtl/regfile_seq_decode.sv | 74 +++++++
 rtl/regfile_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// regfile_seq_pkg: shared types and constants for the PIC16C57 instruction-cycle
// sequencer (widths, phase encoding, opcode fields, decode classes, FSM states).
package regfile_seq_pkg;

  localparam int unsigned INSTR_W = 12;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned PCH_W   = 3;
  localparam int unsigned PHASE_W = 2;
  localparam int unsigned OPF_W   = INSTR_W - ADDR_W;  // opcode field above the file address

  localparam logic [PHASE_W-1:0] PHASE_Q1 = 2'd0;
  localparam logic [PHASE_W-1:0] PHASE_Q2 = 2'd1;
  localparam logic [PHASE_W-1:0] PHASE_Q3 = 2'd2;
  localparam logic [PHASE_W-1:0] PHASE_Q4 = 2'd3;

  localparam logic [ADDR_W-1:0] PCL_ADDR    = 5'h02;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = 5'h03;

  // Instruction groups, instr[11:10]
  localparam logic [1:0] GRP_BYTE = 2'b00;
  localparam logic [1:0] GRP_BIT  = 2'b01;
  localparam logic [1:0] GRP_CTRL = 2'b10;  // RETLW, CALL, GOTO
  localparam logic [1:0] GRP_LIT  = 2'b11;

  // Byte-oriented opcodes, instr[9:6] within GRP_BYTE
  localparam logic [3:0] OP_SYS    = 4'b0000;  // NOP/OPTION/SLEEP/CLRWDT/TRIS (d=0), MOVWF (d=1)
  localparam logic [3:0] OP_DECFSZ = 4'b1011;
  localparam logic [3:0] OP_SWAPF  = 4'b1110;
  localparam logic [3:0] OP_INCFSZ = 4'b1111;

  // Literal opcodes, instr[9:8] within GRP_LIT
  localparam logic [1:0] LIT_MOVLW = 2'b00;

  typedef enum logic [2:0] {
    BYTE_F, BYTE_W, BIT_SET, BIT_SKIP, LIT_W, GOTO, NOP, ILLEGAL
  } decode_class_e;

  typedef enum logic [1:0] {DEST_NONE, DEST_F, DEST_W, DEST_PCL} dest_e;

  typedef enum logic [1:0] {SKIP_NONE, SKIP_ZERO, SKIP_BIT_CLR, SKIP_BIT_SET} skip_e;

  typedef enum logic [2:0] {ST_IDLE, ST_Q1, ST_Q2, ST_Q3, ST_Q4, ST_HALT} state_e;

  // Phase number presented while sitting in a state; IDLE and HALT report Q1.
  function automatic logic [PHASE_W-1:0] phase_of(input state_e s);
    case (s)
      ST_Q2:   return PHASE_Q2;
      ST_Q3:   return PHASE_Q3;
      ST_Q4:   return PHASE_Q4;
      default: return PHASE_Q1;
    endcase
  endfunction

endpackage

// File: rtl/regfile_seq_decode.sv
// regfile_seq_decode: combinational instruction decoder.
// Ports:
//   op_i         in  instr[11:5] (opcode, d / bit-number field)
//   cls_o        out decode class
//   status_upd_o out instruction updates STATUS in Q3
//   dest_o       out Q4 destination (none, file, W, PCL)
//   skip_o       out skip condition evaluated at the end of Q3
module regfile_seq_decode
  import regfile_seq_pkg::*;
(
  input  logic [OPF_W-1:0] op_i,
  output decode_class_e    cls_o,
  output logic             status_upd_o,
  output dest_e            dest_o,
  output skip_e            skip_o
);

  logic [1:0] grp;
  logic [3:0] bop;
  logic       d_bit;

  assign grp   = op_i[6:5];
  assign bop   = op_i[4:1];
  assign d_bit = op_i[0];

  always_comb begin
    cls_o        = NOP;
    status_upd_o = 1'b0;
    dest_o       = DEST_NONE;
    skip_o       = SKIP_NONE;
    case (grp)
      GRP_BYTE: begin
        if (bop == OP_SYS) begin
          // Only MOVWF does anything here; the system ops are sequencer NOPs.
          if (d_bit) begin
            cls_o  = BYTE_F;
            dest_o = DEST_F;
          end
        end else begin
          cls_o        = d_bit ? BYTE_F : BYTE_W;
          dest_o       = d_bit ? DEST_F : DEST_W;
          status_upd_o = !(bop inside {OP_DECFSZ, OP_SWAPF, OP_INCFSZ});
          if (bop == OP_DECFSZ || bop == OP_INCFSZ) skip_o = SKIP_ZERO;
        end
      end
      GRP_BIT: begin
        // instr[9]: test vs modify; instr[8]: set vs clear polarity
        if (op_i[4]) begin
          cls_o  = BIT_SKIP;
          skip_o = op_i[3] ? SKIP_BIT_SET : SKIP_BIT_CLR;
        end else begin
          cls_o  = BIT_SET;
          dest_o = DEST_F;
        end
      end
      GRP_CTRL: begin
        // 101k = GOTO; 1000 RETLW and 1001 CALL need a stack this core lacks
        if (op_i[4]) begin
          cls_o  = GOTO;
          dest_o = DEST_PCL;
        end else begin
          cls_o = ILLEGAL;
        end
      end
      GRP_LIT: begin
        cls_o        = LIT_W;
        dest_o       = DEST_W;
        status_upd_o = (op_i[4:3] != LIT_MOVLW);
      end
      default: cls_o = NOP;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: Q1-Q4 instruction-cycle controller for the PIC16C57 core.
// Latches each instruction, decodes it and issues register-file commands so that
// PCInc (Q1), StatusEn (Q3) and write (Q4) never share a clock.
// Optional build macro: SEQ_ILLEGAL_TRAP_EN -- an unsupported opcode parks the
// sequencer in HALT after Q2 until reset; otherwise it executes as a NOP.
// Ports:
//   clk, rst (sync, active-high), run (start/continue, sampled in IDLE and Q4)
//   instrIn, fileDataIn, statusIn, aluResultIn, aluZeroIn   datapath inputs
//   addressOut, writeOut, PCIncOut, StatusEnOut, dataOut, PCHOut   register file
//   wWriteOut (W load), instrOut (to ALU), phaseOut, skipOut, illegalOut
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [INSTR_W-1:0] instrIn,
  input  logic [DATA_W-1:0]  fileDataIn,
  input  logic [DATA_W-1:0]  statusIn,
  input  logic [DATA_W-1:0]  aluResultIn,
  input  logic               aluZeroIn,
  output logic [ADDR_W-1:0]  addressOut,
  output logic               writeOut,
  output logic               PCIncOut,
  output logic               StatusEnOut,
  output logic [DATA_W-1:0]  dataOut,
  output logic [PCH_W-1:0]   PCHOut,
  output logic               wWriteOut,
  output logic [INSTR_W-1:0] instrOut,
  output logic [PHASE_W-1:0] phaseOut,
  output logic               skipOut,
  output logic               illegalOut
);

  state_e              state_q, state_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                skip_q, skip_d;          // current cycle squashed
  logic                skip_flag_q, skip_flag_d;  // next cycle to be squashed
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [PCH_W-1:0]    pch_q, pch_d;
  logic                write_q, write_d;
  logic                pcinc_q, pcinc_d;
  logic                staten_q, staten_d;
  logic                wwrite_q, wwrite_d;
  logic                illegal_q, illegal_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;

  logic [INSTR_W-1:0]  cur_instr;
  logic                cur_skip;
  decode_class_e       dec_cls;
  logic                dec_status;
  dest_e               dec_dest;
  skip_e               dec_skip;
  logic                test_bit;
  logic                unused_status;

  // The word is latched at the end of Q1, so decisions made on that edge
  // look straight at instrIn and the pending skip flag.
  assign cur_instr = (state_q == ST_Q1) ? instrIn : instr_q;
  assign cur_skip  = (state_q == ST_Q1) ? skip_flag_q : skip_q;
  assign test_bit  = fileDataIn[instr_q[7:5]];
  assign unused_status = ^{statusIn[7], statusIn[4:0]};

  regfile_seq_decode u_decode (
    .op_i         (cur_instr[INSTR_W-1:ADDR_W]),
    .cls_o        (dec_cls),
    .status_upd_o (dec_status),
    .dest_o       (dec_dest),
    .skip_o       (dec_skip)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, then registered outputs keyed on the state being entered
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    skip_d      = skip_q;
    skip_flag_d = skip_flag_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pch_d       = pch_q;
    write_d     = 1'b0;
    pcinc_d     = 1'b0;
    staten_d    = 1'b0;
    wwrite_d    = 1'b0;
    illegal_d   = 1'b0;

    case (state_q)
      ST_IDLE: if (run) state_d = ST_Q1;
      ST_Q1: begin
        state_d     = ST_Q2;
        instr_d     = instrIn;
        skip_d      = skip_flag_q;
        skip_flag_d = 1'b0;
      end
      ST_Q2: begin
        state_d = ST_Q3;
`ifdef SEQ_ILLEGAL_TRAP_EN
        if (illegal_q) state_d = ST_HALT;
`endif
      end
      ST_Q3: begin
        state_d = ST_Q4;
        if (!skip_q) begin
          case (dec_skip)
            SKIP_ZERO:    skip_flag_d = aluZeroIn;
            SKIP_BIT_CLR: skip_flag_d = !test_bit;
            SKIP_BIT_SET: skip_flag_d = test_bit;
            default:      skip_flag_d = 1'b0;
          endcase
        end
      end
      ST_Q4:   state_d = run ? ST_Q1 : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    phase_d = phase_of(state_d);

    case (state_d)
      ST_Q1: pcinc_d = 1'b1;
      ST_Q2: begin
        addr_d    = cur_instr[ADDR_W-1:0];
        illegal_d = (dec_cls == ILLEGAL) && !cur_skip;
      end
      ST_Q3: staten_d = dec_status && !skip_q;
      ST_Q4: begin
        if (!skip_q) begin
          case (dec_dest)
            DEST_F: begin
              write_d = 1'b1;
              data_d  = aluResultIn;
              pch_d   = {statusIn[6:5], 1'b0};
            end
            DEST_W: wwrite_d = 1'b1;
            DEST_PCL: begin
              // GOTO: PCL <- k[7:0], PC high <- {PA1:PA0, k[8]}
              write_d = 1'b1;
              addr_d  = PCL_ADDR;
              data_d  = instr_q[DATA_W-1:0];
              pch_d   = {statusIn[6:5], instr_q[DATA_W]};
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q     <= '0;
      skip_q      <= 1'b0;
      skip_flag_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      pch_q       <= '0;
      write_q     <= 1'b0;
      pcinc_q     <= 1'b0;
      staten_q    <= 1'b0;
      wwrite_q    <= 1'b0;
      illegal_q   <= 1'b0;
      phase_q     <= PHASE_Q1;
    end else begin
      instr_q     <= instr_d;
      skip_q      <= skip_d;
      skip_flag_q <= skip_flag_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pch_q       <= pch_d;
      write_q     <= write_d;
      pcinc_q     <= pcinc_d;
      staten_q    <= staten_d;
      wwrite_q    <= wwrite_d;
      illegal_q   <= illegal_d;
      phase_q     <= phase_d;
    end
  end

  assign addressOut  = addr_q;
  assign writeOut    = write_q;
  assign PCIncOut    = pcinc_q;
  assign StatusEnOut = staten_q;
  assign dataOut     = data_q;
  assign PCHOut      = pch_q;
  assign wWriteOut   = wwrite_q;
  assign instrOut    = instr_q;
  assign phaseOut    = phase_q;
  assign skipOut     = skip_q;
  assign illegalOut  = illegal_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed self-checking bench for regfile_sequencer.
module tb_regfile_sequencer;
  import regfile_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst, run;
  logic [INSTR_W-1:0] instrIn;
  logic [DATA_W-1:0]  fileDataIn, statusIn, aluResultIn;
  logic               aluZeroIn;
  logic [ADDR_W-1:0]  addressOut;
  logic               writeOut, PCIncOut, StatusEnOut, wWriteOut, skipOut, illegalOut;
  logic [DATA_W-1:0]  dataOut;
  logic [PCH_W-1:0]   PCHOut;
  logic [INSTR_W-1:0] instrOut;
  logic [PHASE_W-1:0] phaseOut;

  int n_total = 0;
  int n_bad   = 0;

  regfile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .instrIn     (instrIn),
    .fileDataIn  (fileDataIn),
    .statusIn    (statusIn),
    .aluResultIn (aluResultIn),
    .aluZeroIn   (aluZeroIn),
    .addressOut  (addressOut),
    .writeOut    (writeOut),
    .PCIncOut    (PCIncOut),
    .StatusEnOut (StatusEnOut),
    .dataOut     (dataOut),
    .PCHOut      (PCHOut),
    .wWriteOut   (wWriteOut),
    .instrOut    (instrOut),
    .phaseOut    (phaseOut),
    .skipOut     (skipOut),
    .illegalOut  (illegalOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({addressOut, writeOut, PCIncOut, StatusEnOut, dataOut, PCHOut,
                wWriteOut, instrOut, phaseOut, skipOut, illegalOut});
  endfunction

  function automatic logic [4:0] strobes();
    return {illegalOut, wWriteOut, StatusEnOut, writeOut, PCIncOut};
  endfunction

  // Entered with the DUT in Q1; runs Q1..Q4 and leaves it at the next state.
  task automatic do_cycle(input string name, input logic [INSTR_W-1:0] instr,
                          input logic [DATA_W-1:0] alu, input logic [DATA_W-1:0] fdata,
                          input logic [DATA_W-1:0] status, input logic zero,
                          input logic e_ill, input logic e_sten, input logic e_wr,
                          input logic e_ww, input logic e_skip,
                          input logic [ADDR_W-1:0] e_addr4, input logic [DATA_W-1:0] e_data,
                          input logic [PCH_W-1:0] e_pch);
    logic [4:0] exp_st [4];
    exp_st[0] = 5'b00001;
    exp_st[1] = {e_ill, 4'b0000};
    exp_st[2] = {2'b00, e_sten, 2'b00};
    exp_st[3] = {1'b0, e_ww, 1'b0, e_wr, 1'b0};
    instrIn     = instr;
    aluResultIn = alu;
    fileDataIn  = fdata;
    statusIn    = status;
    aluZeroIn   = zero;
    for (int p = 0; p < 4; p++) begin
      if (p > 0) step();
      chk({name, "/phase"}, 64'(phaseOut), 64'(p));
      chk({name, "/strobes"}, 64'(strobes()), 64'(exp_st[p]));
      if (p > 0) chk({name, "/skip"}, 64'(skipOut), 64'(e_skip));
      if (p == 1) begin
        chk({name, "/instr"}, 64'(instrOut), 64'(instr));
        chk({name, "/addr_q2"}, 64'(addressOut), 64'(instr[ADDR_W-1:0]));
      end
      if (p == 3) begin
        chk({name, "/addr_q4"}, 64'(addressOut), 64'(e_addr4));
        if (e_wr) begin
          chk({name, "/data"}, 64'(dataOut), 64'(e_data));
          chk({name, "/pch"}, 64'(PCHOut), 64'(e_pch));
        end
      end
    end
    step();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instrIn = '0; fileDataIn = '0;
    statusIn = '0; aluResultIn = '0; aluZeroIn = 1'b0;
    step(); chk("reset1", all_outs(), 64'd0);
    step(); chk("reset2", all_outs(), 64'd0);
    rst = 1'b0; run = 1'b1;
    step();

    //        name        instr    alu    fdata  status z  ill sten wr ww skip addr4      data   pch
    do_cycle("addwf_f",  12'h1F0, 8'h35, 8'h00, 8'h00, 0, 0, 1,  1, 0, 0,   5'h10,     8'h35, 3'b000);
    do_cycle("addwf_w",  12'h1D0, 8'h35, 8'h00, 8'h00, 0, 0, 1,  0, 1, 0,   5'h10,     8'h00, 3'b000);
    do_cycle("goto",     12'hBA5, 8'h00, 8'h00, 8'h40, 0, 0, 0,  1, 0, 0,   PCL_ADDR,  8'hA5, 3'b101);
    do_cycle("btfss",    12'h766, 8'h00, 8'h08, 8'h00, 0, 0, 0,  0, 0, 0,   5'h06,     8'h00, 3'b000);
    do_cycle("movwf_sk", 12'h031, 8'h44, 8'h00, 8'h00, 0, 0, 0,  0, 0, 1,   5'h11,     8'h00, 3'b000);
    do_cycle("movlw",    12'hC5A, 8'h5A, 8'h00, 8'h00, 0, 0, 0,  0, 1, 0,   5'h1A,     8'h00, 3'b000);
    do_cycle("decfsz_0", 12'h2F2, 8'h07, 8'h00, 8'h20, 0, 0, 0,  1, 0, 0,   5'h12,     8'h07, 3'b010);
    do_cycle("decfsz_1", 12'h2F2, 8'h00, 8'h00, 8'h20, 1, 0, 0,  1, 0, 0,   5'h12,     8'h00, 3'b010);
    do_cycle("andlw_sk", 12'hE0F, 8'h00, 8'h00, 8'h00, 0, 0, 0,  0, 0, 1,   5'h0F,     8'h00, 3'b000);
    do_cycle("btfsc_sk", 12'h6A6, 8'h00, 8'h08, 8'h00, 0, 0, 0,  0, 0, 0,   5'h06,     8'h00, 3'b000);
    do_cycle("xorlw_sk", 12'hF33, 8'h00, 8'h00, 8'h00, 0, 0, 0,  0, 0, 1,   5'h13,     8'h00, 3'b000);
    do_cycle("btfsc_ns", 12'h6A6, 8'h00, 8'h20, 8'h00, 0, 0, 0,  0, 0, 0,   5'h06,     8'h00, 3'b000);
    do_cycle("iorlw",    12'hD01, 8'h00, 8'h00, 8'h00, 0, 0, 1,  0, 1, 0,   5'h01,     8'h00, 3'b000);
    do_cycle("bsf",      12'h5E7, 8'h80, 8'h00, 8'h60, 0, 0, 0,  1, 0, 0,   5'h07,     8'h80, 3'b110);
    do_cycle("clrf_st",  12'h063, 8'h00, 8'h00, 8'h00, 0, 0, 1,  1, 0, 0,   STATUS_ADDR, 8'h00, 3'b000);
    do_cycle("nop",      12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0,  0, 0, 0,   5'h00,     8'h00, 3'b000);

    // A pending skip is dropped by reset
    do_cycle("btfss_r",  12'h766, 8'h00, 8'h08, 8'h00, 0, 0, 0,  0, 0, 0,   5'h06,     8'h00, 3'b000);
    rst = 1'b1;
    step(); chk("reset_q1", all_outs(), 64'd0);
    rst = 1'b0;
    step();
    do_cycle("movwf",    12'h031, 8'h44, 8'h00, 8'h00, 0, 0, 0,  1, 0, 0,   5'h11,     8'h44, 3'b000);

    // Reset in the middle of an instruction abandons it
    instrIn = 12'h1F0;
    step(); chk("mid_q2_phase", 64'(phaseOut), 64'(PHASE_Q2));
    rst = 1'b1;
    step(); chk("reset_mid", all_outs(), 64'd0);
    rst = 1'b0;
    step();

`ifdef SEQ_ILLEGAL_TRAP_EN
    instrIn = 12'h905;
    step(); chk("call/illegal", 64'(strobes()), 64'(5'b10000));
    for (int i = 0; i < 6; i++) begin
      step();
      chk("halt/strobes", 64'(strobes()), 64'd0);
      chk("halt/phase", 64'(phaseOut), 64'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`else
    do_cycle("call",     12'h905, 8'h00, 8'h00, 8'h00, 0, 1, 0,  0, 0, 0,   5'h05,     8'h00, 3'b000);
`endif

    // Drop run: last cycle completes, then IDLE with no strobes
    run = 1'b0;
    do_cycle("nop_last", 12'h000, 8'h00, 8'h00, 8'h00, 0, 0, 0,  0, 0, 0,   5'h00,     8'h00, 3'b000);
    for (int i = 0; i < 3; i++) begin
      chk("idle", 64'({strobes(), phaseOut}), 64'd0);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
